// File: rtl/mem_bus_sequencer.sv
// Memory bus sequencer: arbitrates fetch/data requesters and runs LOAD -> ACCESS -> DONE bus cycles.
// Optional macro FAIR_ARB_EN selects round-robin arbitration; undefined gives data-over-fetch fixed priority.
module mem_bus_sequencer #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic fetch_req,
  input  logic data_req,
  input  logic data_we,
  input  logic mem_ready,
  output logic addr_oe_fetch,
  output logic addr_oe_data,
  output logic mar_write,
  output logic mem_read,
  output logic mem_rd,
  output logic mem_wr,
  output logic mdr_load,
  output logic mdr_oe,
  output logic fetch_done,
  output logic data_done,
  output logic busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ACCESS,
    S_DONE
  } state_e;

  localparam logic [3:0] WAIT_INIT = WAIT_CYCLES[3:0];

  state_e     state_q, state_d;
  logic       owner_q, owner_d;  // 1 = data requester owns the bus
  logic       we_q,    we_d;
  logic [3:0] cnt_q,   cnt_d;
  logic       any_req;
  logic       grant_data;

  assign any_req = fetch_req | data_req;

`ifdef FAIR_ARB_EN
  logic last_q, last_d;  // 1 = data was served last

  assign grant_data = data_req & (~fetch_req | ~last_q);

  always_comb begin
    last_d = last_q;
    if (state_q == S_IDLE && any_req) begin
      last_d = grant_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign grant_data = data_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d = grant_data;
          we_d    = grant_data & data_we;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = WAIT_INIT;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (mem_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    addr_oe_fetch = 1'b0;
    addr_oe_data  = 1'b0;
    mar_write     = 1'b0;
    mem_read      = 1'b0;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    mdr_load      = 1'b0;
    mdr_oe        = 1'b0;
    fetch_done    = 1'b0;
    data_done     = 1'b0;
    busy          = (state_q != S_IDLE);
    unique case (state_q)
      S_LOAD: begin
        addr_oe_fetch = ~owner_q;
        addr_oe_data  = owner_q;
        mar_write     = 1'b1;
      end
      S_ACCESS: begin
        mem_read = 1'b1;
        mem_rd   = ~we_q;
        mem_wr   = we_q;
        mdr_oe   = we_q;
        // final cycle of a read: wait count expired and memory ready
        mdr_load = ~we_q & (cnt_q == '0) & mem_ready;
      end
      S_DONE: begin
        fetch_done = ~owner_q;
        data_done  = owner_q;
      end
      default: begin
      end
    endcase
  end

  a_oe_onehot: assert property (@(posedge clk) disable iff (!reset)
    !(addr_oe_fetch && addr_oe_data));
  a_rd_wr_excl: assert property (@(posedge clk) disable iff (!reset)
    !(mem_rd && mem_wr));
  a_done_excl: assert property (@(posedge clk) disable iff (!reset)
    !(fetch_done && data_done));

endmodule
